// File: rtl/ts_pkg.sv
// Shared definitions for the TS stream stages: sync byte, packet length, aligner states.
package ts_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'h47;
  localparam int unsigned TS_PKT_LEN = 188;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } ts_state_e;

endpackage : ts_pkg

// File: rtl/ts_sync_lock.sv
// TS packet aligner: hunts for the sync byte, verifies it on the packet grid,
// then forwards aligned bytes with a start-of-packet marker until sync is lost.
module ts_sync_lock
  import ts_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = TS_PKT_LEN,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] ts_data,
  output logic                  valid_out,
  output logic                  sop_out,
  output logic [DATA_WIDTH-1:0] ts_data_out,
  output logic                  locked,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           sync_loss_cnt
);

  localparam int unsigned POS_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [POS_W-1:0]      POS_LAST  = POS_W'(PKT_LEN - 1);
  localparam logic [HIT_W-1:0]      HIT_GOAL  = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]     MISS_GOAL = MISS_W'(UNLOCK_CNT);
  localparam logic [DATA_WIDTH-1:0] SYNC_VAL  = DATA_WIDTH'(SYNC_BYTE);

  ts_state_e             state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [HIT_W-1:0]      hits_q, hits_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic                  valid_out_q, valid_out_d;
  logic                  sop_out_q, sop_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  locked_q, locked_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [15:0]           loss_cnt_q, loss_cnt_d;

  logic                  is_sync;
  logic                  at_sync_pos;
  logic [POS_W-1:0]      pos_next;
  logic [HIT_W-1:0]      hits_inc;
  logic [MISS_W-1:0]     miss_inc;

  // Byte classification and counter increments shared by all states
  always_comb begin
    is_sync     = (ts_data == SYNC_VAL);
    at_sync_pos = (pos_q == '0);
    pos_next    = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    hits_inc    = hits_q + HIT_W'(1);
    miss_inc    = miss_q + MISS_W'(1);
  end

  // Next-state, counter and output-register logic; everything holds on idle cycles
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hits_d      = hits_q;
    miss_d      = miss_q;
    valid_out_d = 1'b0;
    sop_out_d   = 1'b0;
    data_out_d  = data_out_q;
    pkt_cnt_d   = pkt_cnt_q;
    loss_cnt_d  = loss_cnt_q;

    if (valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            hits_d = HIT_W'(1);
            pos_d  = pos_next;
            if (HIT_W'(1) >= HIT_GOAL) begin
              // Degenerate single-hit lock: the sync byte itself opens the stream
              state_d     = ST_LOCK;
              miss_d      = '0;
              valid_out_d = 1'b1;
              sop_out_d   = 1'b1;
              data_out_d  = ts_data;
              pkt_cnt_d   = pkt_cnt_q + 32'd1;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          pos_d = pos_next;
          if (at_sync_pos) begin
            if (is_sync) begin
              hits_d = hits_inc;
              if (hits_inc >= HIT_GOAL) begin
                state_d     = ST_LOCK;
                miss_d      = '0;
                valid_out_d = 1'b1;
                sop_out_d   = 1'b1;
                data_out_d  = ts_data;
                pkt_cnt_d   = pkt_cnt_q + 32'd1;
              end
            end else begin
              state_d = ST_HUNT;
              pos_d   = '0;
              hits_d  = '0;
            end
          end
        end

        ST_LOCK: begin
          pos_d       = pos_next;
          valid_out_d = 1'b1;
          data_out_d  = ts_data;
          if (at_sync_pos) begin
            if (is_sync) begin
              miss_d    = '0;
              sop_out_d = 1'b1;
              pkt_cnt_d = pkt_cnt_q + 32'd1;
            end else if (miss_inc >= MISS_GOAL) begin
              // Sync lost: drop this byte and restart alignment
              state_d     = ST_HUNT;
              pos_d       = '0;
              hits_d      = '0;
              miss_d      = '0;
              valid_out_d = 1'b0;
              data_out_d  = data_out_q;
              loss_cnt_d  = (loss_cnt_q != 16'hFFFF) ? loss_cnt_q + 16'd1 : loss_cnt_q;
            end else begin
              miss_d    = miss_inc;
              sop_out_d = 1'b1;
              pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
          pos_d   = '0;
          hits_d  = '0;
          miss_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCK);
  end

  // State, counters and registered outputs
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      pos_q       <= '0;
      hits_q      <= '0;
      miss_q      <= '0;
      valid_out_q <= 1'b0;
      sop_out_q   <= 1'b0;
      data_out_q  <= '0;
      locked_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hits_q      <= hits_d;
      miss_q      <= miss_d;
      valid_out_q <= valid_out_d;
      sop_out_q   <= sop_out_d;
      data_out_q  <= data_out_d;
      locked_q    <= locked_d;
      pkt_cnt_q   <= pkt_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign valid_out     = valid_out_q;
  assign sop_out       = sop_out_q;
  assign ts_data_out   = data_out_q;
  assign locked        = locked_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign sync_loss_cnt = loss_cnt_q;

endmodule : ts_sync_lock

// File: tb/tb_ts_sync_lock.sv
// Scoreboard bench for ts_sync_lock: expected forwarded bytes are queued as the
// stream is driven and popped when the aligner produces them.
module tb_ts_sync_lock;

  localparam int unsigned PL = 188;

  logic        wclk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  ts_data;
  logic        valid_out;
  logic        sop_out;
  logic [7:0]  ts_data_out;
  logic        locked;
  logic [31:0] pkt_cnt;
  logic [15:0] sync_loss_cnt;

  typedef struct packed {
    logic       sop;
    logic [7:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pkt;
  logic [15:0] exp_loss;
  logic [7:0]  last_out;
  logic        exp_locked;

  ts_sync_lock #(
    .DATA_WIDTH (8),
    .PKT_LEN    (PL),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (2)
  ) dut (
    .wclk          (wclk),
    .rst_n         (rst_n),
    .valid         (valid),
    .ts_data       (ts_data),
    .valid_out     (valid_out),
    .sop_out       (sop_out),
    .ts_data_out   (ts_data_out),
    .locked        (locked),
    .pkt_cnt       (pkt_cnt),
    .sync_loss_cnt (sync_loss_cnt)
  );

  always #5 wclk = ~wclk;

  function automatic logic [7:0] payload_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h47) b = 8'h48;
    return b;
  endfunction

  // One valid byte; fwd says whether the aligner must pass it on
  task automatic drive_byte(input logic [7:0] b, input bit fwd, input bit sop);
    exp_t e;
    valid   = 1'b1;
    ts_data = b;
    if (fwd) begin
      sb_q.push_back({sop, b});
      if (sop) exp_pkt = exp_pkt + 32'd1;
      last_out = b;
    end
    exp_locked = fwd;
    @(posedge wclk); #1;
    valid = 1'b0;
    checks++;
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%h sop=%b, required no valid_out", ts_data_out, sop_out);
      end else begin
        e = sb_q.pop_front();
        if ({sop_out, ts_data_out} !== e) begin
          errors++;
          $display("FAIL output_byte: got sop=%b data=%h, required sop=%b data=%h", sop_out, ts_data_out, e.sop, e.data);
        end
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      errors++;
      $display("FAIL missing_output: valid_out=%b, required data=%h sop=%b", valid_out, e.data, e.sop);
    end else if (sop_out !== 1'b0 || ts_data_out !== last_out) begin
      errors++;
      $display("FAIL idle_hold: got sop=%b data=%h, required sop=0 data=%h", sop_out, ts_data_out, last_out);
    end
    checks++;
    if (locked !== exp_locked) begin
      errors++;
      $display("FAIL locked: got %b, required %b", locked, exp_locked);
    end
    checks++;
    if (pkt_cnt !== exp_pkt) begin
      errors++;
      $display("FAIL pkt_cnt: got %0d, required %0d", pkt_cnt, exp_pkt);
    end
    checks++;
    if (sync_loss_cnt !== exp_loss) begin
      errors++;
      $display("FAIL sync_loss_cnt: got %0d, required %0d", sync_loss_cnt, exp_loss);
    end
  endtask

  // One idle cycle: nothing may move
  task automatic idle_cycle();
    valid   = 1'b0;
    ts_data = 8'h47;
    @(posedge wclk); #1;
    checks++;
    if (valid_out !== 1'b0 || sop_out !== 1'b0 || ts_data_out !== last_out ||
        locked !== exp_locked || pkt_cnt !== exp_pkt) begin
      errors++;
      $display("FAIL gap_hold: got v=%b sop=%b data=%h lk=%b pkts=%0d, required v=0 sop=0 data=%h lk=%b pkts=%0d",
               valid_out, sop_out, ts_data_out, locked, pkt_cnt, last_out, exp_locked, exp_pkt);
    end
  endtask

  task automatic send_packet(input logic [7:0] sync, input bit fwd, input int gap_pct, input bit stray);
    logic [7:0] b;
    for (int i = 0; i < int'(PL); i++) begin
      b = (i == 0) ? sync : payload_byte();
      if (stray && (i == 5 || i == 100)) b = 8'h47;
      while (int'($urandom_range(99)) < gap_pct) idle_cycle();
      drive_byte(b, fwd, i == 0);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || sop_out !== 1'b0 || ts_data_out !== 8'h00 ||
        locked !== 1'b0 || pkt_cnt !== 32'd0 || sync_loss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: got v=%b sop=%b data=%h lk=%b pkts=%0d loss=%0d, required all zero",
               tag, valid_out, sop_out, ts_data_out, locked, pkt_cnt, sync_loss_cnt);
    end
    @(posedge wclk); #1;
    rst_n = 1'b1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d queued bytes, required 0", tag, sb_q.size());
    end
    sb_q.delete();
    exp_pkt    = '0;
    exp_loss   = '0;
    last_out   = '0;
    exp_locked = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid   = 1'b0;
    ts_data = 8'h47;
    exp_pkt = '0; exp_loss = '0; last_out = '0; exp_locked = 1'b0;
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b, required 0", valid_out); end
    checks++;
    if (sop_out !== 1'b0) begin errors++; $display("FAIL reset_sop_out: got %b, required 0", sop_out); end
    checks++;
    if (ts_data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", ts_data_out); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b, required 0", locked); end
    checks++;
    if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
    checks++;
    if (sync_loss_cnt !== 16'd0) begin errors++; $display("FAIL reset_loss: got %0d, required 0", sync_loss_cnt); end
    @(posedge wclk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lock_acquire();
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b1, 0, 1'b0);
    checks++;
    if (pkt_cnt !== 32'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL first_lock: got pkts=%0d lk=%b, required pkts=1 lk=1", pkt_cnt, locked);
    end
  endtask

  task automatic test_single_bad_sync();
    send_packet(8'h00, 1'b1, 0, 1'b0);
    send_packet(8'h47, 1'b1, 0, 1'b0);
  endtask

  task automatic test_unlock_relock();
    send_packet(8'h00, 1'b1, 0, 1'b0);
    exp_loss = exp_loss + 16'd1;
    send_packet(8'h12, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b1, 0, 1'b0);
    send_packet(8'h47, 1'b1, 0, 1'b0);
  endtask

  task automatic test_gaps();
    for (int p = 0; p < 4; p++) send_packet(8'h47, 1'b1, 30, 1'b1);
  endtask

  task automatic test_reset_midpacket();
    for (int i = 0; i < 90; i++) drive_byte((i == 0) ? 8'h47 : payload_byte(), 1'b1, i == 0);
    pulse_reset("midpkt_reset");
    for (int i = 90; i < int'(PL); i++) drive_byte(payload_byte(), 1'b0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b1, 0, 1'b0);
  endtask

  task automatic test_garbage();
    pulse_reset("garbage_reset");
    for (int i = 0; i < 50; i++) drive_byte((i == 10 || i == 30) ? 8'h47 : payload_byte(), 1'b0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b0, 0, 1'b0);
    send_packet(8'h47, 1'b1, 0, 1'b0);
    send_packet(8'h47, 1'b1, 10, 1'b1);
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_bad_sync();
    test_unlock_relock();
    test_gaps();
    test_reset_midpacket();
    test_garbage();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ts_sync_lock
